// File: rtl/sample_frame_if.sv
// sample_frame_if: front-end, frame-buffer write port and frame handoff signals
// master modport is the controller side; slave is the surrounding environment.
interface sample_frame_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 12
);
    logic                  enable;
    logic                  conv_start;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_data;
    logic                  buf_we;
    logic [ADDR_WIDTH:0]   buf_addr;
    logic [DATA_WIDTH-1:0] buf_wdata;
    logic                  frame_valid;
    logic                  frame_bank;
    logic                  frame_ready;
    logic                  overrun;
    logic [7:0]            drop_count;

    modport master (
        input  enable, sample_valid, sample_data, frame_ready,
        output conv_start, buf_we, buf_addr, buf_wdata, frame_valid, frame_bank, overrun, drop_count
    );

    modport slave (
        output enable, sample_valid, sample_data, frame_ready,
        input  conv_start, buf_we, buf_addr, buf_wdata, frame_valid, frame_bank, overrun, drop_count
    );
endinterface

// File: rtl/sample_frame_controller.sv
// sample_frame_controller: ADC conversion timer plus ping-pong frame collector
// with valid/ready ownership handoff of completed banks to the consumer.
module sample_frame_controller #(
    parameter int CONV_PERIOD = 100,
    parameter int FRAME_LEN   = 1024,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 12
) (
    input logic           clk_100mhz,
    input logic           rst,
    sample_frame_if.master bus
);
    localparam int CW = $clog2(CONV_PERIOD);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic                  fill_bank, bank_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt;
    logic                  done, done_nxt;
    logic                  wr, drop, publish, rel, wbank;
    logic                  buf_we, frame_valid, frame_bank, overrun;
    logic [ADDR_WIDTH:0]   buf_addr;
    logic [DATA_WIDTH-1:0] buf_wdata;
    logic [7:0]            drop_count;

    assign bus.conv_start  = bus.enable & (state != IDLE) & (cnt == CW'(CONV_PERIOD - 1));
    assign bus.buf_we      = buf_we;
    assign bus.buf_addr    = buf_addr;
    assign bus.buf_wdata   = buf_wdata;
    assign bus.frame_valid = frame_valid;
    assign bus.frame_bank  = frame_bank;
    assign bus.overrun     = overrun;
    assign bus.drop_count  = drop_count;

    // done marks the cycle of a frame's final write; the bank decision is taken
    // then, so a sample in that cycle goes straight to the freed bank or is dropped
    always_comb begin
        state_nxt = state;
        bank_nxt  = fill_bank;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        wr        = 1'b0;
        drop      = 1'b0;
        publish   = 1'b0;
        wbank     = fill_bank;
        rel       = frame_valid & bus.frame_ready;
        if (!bus.enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: state_nxt = FILL;
                FILL: begin
                    publish   = done & (~frame_valid | rel);
                    wbank     = done ? ~fill_bank : fill_bank;
                    bank_nxt  = publish ? ~fill_bank : fill_bank;
                    state_nxt = (done & ~publish) ? WAIT_BANK : FILL;
                    wr        = bus.sample_valid & (~done | publish);
                    drop      = bus.sample_valid & done & ~publish;
                    if (wr) begin
                        idx_nxt  = idx + 1'b1;
                        done_nxt = idx == ADDR_WIDTH'(FRAME_LEN - 1);
                    end
                end
                WAIT_BANK: begin
                    drop      = bus.sample_valid;
                    publish   = rel;
                    bank_nxt  = rel ? ~fill_bank : fill_bank;
                    idx_nxt   = rel ? '0 : idx;
                    state_nxt = rel ? FILL : WAIT_BANK;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            fill_bank   <= 1'b0;
            idx         <= '0;
            done        <= 1'b0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            frame_valid <= 1'b0;
            frame_bank  <= 1'b0;
            overrun     <= 1'b0;
            drop_count  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= (!bus.enable || state == IDLE || cnt == CW'(CONV_PERIOD - 1)) ? '0 : cnt + 1'b1;
            fill_bank   <= bank_nxt;
            idx         <= idx_nxt;
            done        <= done_nxt;
            buf_we      <= wr;
            buf_addr    <= wr ? {wbank, idx} : buf_addr;
            buf_wdata   <= wr ? bus.sample_data : buf_wdata;
            frame_valid <= publish | (frame_valid & ~bus.frame_ready);
            frame_bank  <= publish ? fill_bank : frame_bank;
            overrun     <= overrun | drop;
            drop_count  <= (drop && drop_count != 8'hff) ? drop_count + 1'b1 : drop_count;
        end
    end
endmodule
